// File: rtl/sc_gamestatus_if.sv
// Command/status bundle between the game controller and the status block.
// Inputs are active-low one-cycle event strobes.
interface sc_gamestatus_if;
  logic       SC_GAMESTATUS_StartGame_InLow;
  logic       SC_GAMESTATUS_LifesSignal_InLow;
  logic       SC_GAMESTATUS_LoadLastRegister_InLow;
  logic       SC_GAMESTATUS_ClearLost_InLow;
  logic [2:0] SC_GAMESTATUS_HouseIndex_InBUS;
  logic       SC_GAMESTATUS_LifesComparator_OutLow;
  logic       SC_GAMESTATUS_LevelComparator_OutLow;
  logic       SC_GAMESTATUS_NextLevel_OutLow;
  logic [1:0] SC_GAMESTATUS_Lifes_OutBUS;
  logic [2:0] SC_GAMESTATUS_Level_OutBUS;
  logic [4:0] SC_GAMESTATUS_Houses_OutBUS;

  modport master (
    output SC_GAMESTATUS_StartGame_InLow, SC_GAMESTATUS_LifesSignal_InLow,
           SC_GAMESTATUS_LoadLastRegister_InLow, SC_GAMESTATUS_ClearLost_InLow,
           SC_GAMESTATUS_HouseIndex_InBUS,
    input  SC_GAMESTATUS_LifesComparator_OutLow, SC_GAMESTATUS_LevelComparator_OutLow,
           SC_GAMESTATUS_NextLevel_OutLow, SC_GAMESTATUS_Lifes_OutBUS,
           SC_GAMESTATUS_Level_OutBUS, SC_GAMESTATUS_Houses_OutBUS
  );

  modport slave (
    input  SC_GAMESTATUS_StartGame_InLow, SC_GAMESTATUS_LifesSignal_InLow,
           SC_GAMESTATUS_LoadLastRegister_InLow, SC_GAMESTATUS_ClearLost_InLow,
           SC_GAMESTATUS_HouseIndex_InBUS,
    output SC_GAMESTATUS_LifesComparator_OutLow, SC_GAMESTATUS_LevelComparator_OutLow,
           SC_GAMESTATUS_NextLevel_OutLow, SC_GAMESTATUS_Lifes_OutBUS,
           SC_GAMESTATUS_Level_OutBUS, SC_GAMESTATUS_Houses_OutBUS
  );
endinterface

// File: rtl/sc_gamestatus.sv
// Game status tracker: lives, completed levels and goal-house occupancy.
// Optional macro SC_GAMESTATUS_EXTRALIFE_EN grants one life per completed level.
module sc_gamestatus #(
  parameter int unsigned INIT_LIFES = 3,
  parameter int unsigned NUM_HOUSES = 5,
  parameter int unsigned MAX_LEVEL  = 4
) (
  input  logic             SC_GAMESTATUS_CLOCK_50,
  input  logic             SC_GAMESTATUS_RESET_InHigh,
  sc_gamestatus_if.slave   gameBus
);

  localparam int unsigned LIFES_W  = 2;
  localparam int unsigned LEVEL_W  = 3;
  localparam int unsigned HOUSES_W = 5;

  localparam logic [LIFES_W-1:0]  LIFES_INIT = LIFES_W'(INIT_LIFES);
  localparam logic [LIFES_W-1:0]  LIFES_MAX  = LIFES_W'(3);
  localparam logic [LEVEL_W-1:0]  LEVEL_MAX  = LEVEL_W'(MAX_LEVEL);
  localparam logic [HOUSES_W-1:0] FULL_MASK  = HOUSES_W'((32'd1 << NUM_HOUSES) - 32'd1);

  typedef enum logic [1:0] {IDLE, PLAY, LEVELUP, HALT} state_t;

  state_t               state, stateNext;
  logic [LIFES_W-1:0]   lifesReg, lifesNext;
  logic [LEVEL_W-1:0]   levelReg, levelNext;
  logic [HOUSES_W-1:0]  housesReg, housesNext;
  logic                 nextLevelReg, nextLevelNext;
  logic [HOUSES_W-1:0]  houseBit, housesSet;
  logic                 houseValid;

  // State and registered outputs
  always_ff @(posedge SC_GAMESTATUS_CLOCK_50 or posedge SC_GAMESTATUS_RESET_InHigh) begin
    if (SC_GAMESTATUS_RESET_InHigh) begin
      state        <= IDLE;
      lifesReg     <= '0;
      levelReg     <= '0;
      housesReg    <= '0;
      nextLevelReg <= 1'b1;
    end else begin
      state        <= stateNext;
      lifesReg     <= lifesNext;
      levelReg     <= levelNext;
      housesReg    <= housesNext;
      nextLevelReg <= nextLevelNext;
    end
  end

  // Next state and next register values; StartGame wins over everything
  always_comb begin
    stateNext     = state;
    lifesNext     = lifesReg;
    levelNext     = levelReg;
    housesNext    = housesReg;
    nextLevelNext = 1'b1;
    houseBit      = HOUSES_W'(5'b00001 << gameBus.SC_GAMESTATUS_HouseIndex_InBUS);
    housesSet     = housesReg | houseBit;
    houseValid    = (32'(gameBus.SC_GAMESTATUS_HouseIndex_InBUS) < NUM_HOUSES) &&
                    ((housesReg & houseBit) == '0);

    if (!gameBus.SC_GAMESTATUS_StartGame_InLow) begin
      stateNext  = PLAY;
      lifesNext  = LIFES_INIT;
      levelNext  = '0;
      housesNext = '0;
    end else begin
      case (state)
        IDLE: begin
          if (!gameBus.SC_GAMESTATUS_ClearLost_InLow) begin
            housesNext = '0;
            stateNext  = HALT;
          end
        end
        PLAY: begin
          if (!gameBus.SC_GAMESTATUS_ClearLost_InLow) begin
            housesNext = '0;
            stateNext  = HALT;
          end else if (!gameBus.SC_GAMESTATUS_LifesSignal_InLow) begin
            if (lifesReg != '0) lifesNext = lifesReg - LIFES_W'(1);
          end else if (!gameBus.SC_GAMESTATUS_LoadLastRegister_InLow && houseValid) begin
            housesNext = housesSet;
            // The pulse register is loaded now so it is low during LEVELUP
            if (housesSet == FULL_MASK) begin
              stateNext     = LEVELUP;
              nextLevelNext = 1'b0;
            end
          end
        end
        LEVELUP: begin
          if (levelReg != LEVEL_MAX) levelNext = levelReg + LEVEL_W'(1);
          housesNext = '0;
`ifdef SC_GAMESTATUS_EXTRALIFE_EN
          if (lifesReg != LIFES_MAX) lifesNext = lifesReg + LIFES_W'(1);
`endif
          stateNext  = PLAY;
        end
        HALT: begin
          stateNext = HALT;
        end
        default: stateNext = IDLE;
      endcase
    end
  end

  // Saturation ceiling only matters when the extra-life feature is built
  logic unusedLifesMax;
  assign unusedLifesMax = ^LIFES_MAX;

  assign gameBus.SC_GAMESTATUS_Lifes_OutBUS           = lifesReg;
  assign gameBus.SC_GAMESTATUS_Level_OutBUS           = levelReg;
  assign gameBus.SC_GAMESTATUS_Houses_OutBUS          = housesReg;
  assign gameBus.SC_GAMESTATUS_NextLevel_OutLow       = nextLevelReg;
  assign gameBus.SC_GAMESTATUS_LifesComparator_OutLow = (lifesReg != '0);
  assign gameBus.SC_GAMESTATUS_LevelComparator_OutLow = (levelReg != LEVEL_MAX);

endmodule

// File: tb/tb_sc_gamestatus.sv
// Directed self-checking bench for sc_gamestatus (default parameters).
module tb_sc_gamestatus;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  logic [7:0] expBonusLifes;

  sc_gamestatus_if gameBus();

  sc_gamestatus #(
    .INIT_LIFES (3),
    .NUM_HOUSES (5),
    .MAX_LEVEL  (4)
  ) dut (
    .SC_GAMESTATUS_CLOCK_50     (clk),
    .SC_GAMESTATUS_RESET_InHigh (rst),
    .gameBus                    (gameBus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulseStart();
    gameBus.SC_GAMESTATUS_StartGame_InLow = 1'b0;
    step();
    gameBus.SC_GAMESTATUS_StartGame_InLow = 1'b1;
  endtask

  task automatic pulseLifes();
    gameBus.SC_GAMESTATUS_LifesSignal_InLow = 1'b0;
    step();
    gameBus.SC_GAMESTATUS_LifesSignal_InLow = 1'b1;
  endtask

  task automatic pulseLoad(input logic [2:0] idx);
    gameBus.SC_GAMESTATUS_HouseIndex_InBUS       = idx;
    gameBus.SC_GAMESTATUS_LoadLastRegister_InLow = 1'b0;
    step();
    gameBus.SC_GAMESTATUS_LoadLastRegister_InLow = 1'b1;
  endtask

  task automatic pulseClear();
    gameBus.SC_GAMESTATUS_ClearLost_InLow = 1'b0;
    step();
    gameBus.SC_GAMESTATUS_ClearLost_InLow = 1'b1;
  endtask

  task automatic completeLevel();
    for (int i = 0; i < 5; i++) pulseLoad(3'(i));
    chk("levelup_pulse", 8'(gameBus.SC_GAMESTATUS_NextLevel_OutLow), 8'h00);
    step();
    chk("levelup_pulse_end", 8'(gameBus.SC_GAMESTATUS_NextLevel_OutLow), 8'h01);
    chk("levelup_houses", 8'(gameBus.SC_GAMESTATUS_Houses_OutBUS), 8'h00);
  endtask

  initial begin
    checks = 0;
    errors = 0;
`ifdef SC_GAMESTATUS_EXTRALIFE_EN
    expBonusLifes = 8'h03;
`else
    expBonusLifes = 8'h02;
`endif
    gameBus.SC_GAMESTATUS_StartGame_InLow        = 1'b1;
    gameBus.SC_GAMESTATUS_LifesSignal_InLow      = 1'b1;
    gameBus.SC_GAMESTATUS_LoadLastRegister_InLow = 1'b1;
    gameBus.SC_GAMESTATUS_ClearLost_InLow        = 1'b1;
    gameBus.SC_GAMESTATUS_HouseIndex_InBUS       = 3'd0;
    rst = 1'b1;
    step();
    step();

    // Reset state
    chk("rst_lifes",   8'(gameBus.SC_GAMESTATUS_Lifes_OutBUS), 8'h00);
    chk("rst_level",   8'(gameBus.SC_GAMESTATUS_Level_OutBUS), 8'h00);
    chk("rst_houses",  8'(gameBus.SC_GAMESTATUS_Houses_OutBUS), 8'h00);
    chk("rst_next",    8'(gameBus.SC_GAMESTATUS_NextLevel_OutLow), 8'h01);
    chk("rst_lifecmp", 8'(gameBus.SC_GAMESTATUS_LifesComparator_OutLow), 8'h00);
    chk("rst_lvlcmp",  8'(gameBus.SC_GAMESTATUS_LevelComparator_OutLow), 8'h01);
    rst = 1'b0;
    step();

    // Game start
    pulseStart();
    chk("start_lifes",   8'(gameBus.SC_GAMESTATUS_Lifes_OutBUS), 8'h03);
    chk("start_level",   8'(gameBus.SC_GAMESTATUS_Level_OutBUS), 8'h00);
    chk("start_houses",  8'(gameBus.SC_GAMESTATUS_Houses_OutBUS), 8'h00);
    chk("start_lifecmp", 8'(gameBus.SC_GAMESTATUS_LifesComparator_OutLow), 8'h01);
    chk("start_lvlcmp",  8'(gameBus.SC_GAMESTATUS_LevelComparator_OutLow), 8'h01);

    // House filling with a duplicate and an out-of-range index
    pulseLoad(3'd0); chk("house0",   8'(gameBus.SC_GAMESTATUS_Houses_OutBUS), 8'h01);
    pulseLoad(3'd1); chk("house1",   8'(gameBus.SC_GAMESTATUS_Houses_OutBUS), 8'h03);
    pulseLoad(3'd1); chk("house1dup",8'(gameBus.SC_GAMESTATUS_Houses_OutBUS), 8'h03);
    pulseLoad(3'd2); chk("house2",   8'(gameBus.SC_GAMESTATUS_Houses_OutBUS), 8'h07);
    pulseLoad(3'd3); chk("house3",   8'(gameBus.SC_GAMESTATUS_Houses_OutBUS), 8'h0f);
    pulseLoad(3'd7); chk("house7",   8'(gameBus.SC_GAMESTATUS_Houses_OutBUS), 8'h0f);
    chk("house7_next", 8'(gameBus.SC_GAMESTATUS_NextLevel_OutLow), 8'h01);
    pulseLoad(3'd4);
    chk("house4_full",  8'(gameBus.SC_GAMESTATUS_Houses_OutBUS), 8'h1f);
    chk("house4_pulse", 8'(gameBus.SC_GAMESTATUS_NextLevel_OutLow), 8'h00);
    chk("house4_lvl0",  8'(gameBus.SC_GAMESTATUS_Level_OutBUS), 8'h00);
    step();
    chk("lvl1_level",  8'(gameBus.SC_GAMESTATUS_Level_OutBUS), 8'h01);
    chk("lvl1_houses", 8'(gameBus.SC_GAMESTATUS_Houses_OutBUS), 8'h00);
    chk("lvl1_next",   8'(gameBus.SC_GAMESTATUS_NextLevel_OutLow), 8'h01);
    chk("lvl1_lifes",  8'(gameBus.SC_GAMESTATUS_Lifes_OutBUS), 8'h03);

    // Simultaneous life loss and house load: only the loss applies
    gameBus.SC_GAMESTATUS_HouseIndex_InBUS       = 3'd0;
    gameBus.SC_GAMESTATUS_LoadLastRegister_InLow = 1'b0;
    gameBus.SC_GAMESTATUS_LifesSignal_InLow      = 1'b0;
    step();
    gameBus.SC_GAMESTATUS_LoadLastRegister_InLow = 1'b1;
    gameBus.SC_GAMESTATUS_LifesSignal_InLow      = 1'b1;
    chk("both_lifes",  8'(gameBus.SC_GAMESTATUS_Lifes_OutBUS), 8'h02);
    chk("both_houses", 8'(gameBus.SC_GAMESTATUS_Houses_OutBUS), 8'h00);

    // Lives saturate at zero
    pulseLifes(); chk("lifes1", 8'(gameBus.SC_GAMESTATUS_Lifes_OutBUS), 8'h01);
    chk("lifes1_cmp", 8'(gameBus.SC_GAMESTATUS_LifesComparator_OutLow), 8'h01);
    pulseLifes(); chk("lifes0", 8'(gameBus.SC_GAMESTATUS_Lifes_OutBUS), 8'h00);
    chk("lifes0_cmp", 8'(gameBus.SC_GAMESTATUS_LifesComparator_OutLow), 8'h00);
    pulseLifes(); chk("lifes_sat", 8'(gameBus.SC_GAMESTATUS_Lifes_OutBUS), 8'h00);
    chk("lifes_sat_cmp", 8'(gameBus.SC_GAMESTATUS_LifesComparator_OutLow), 8'h00);

    // StartGame in PLAY beats a simultaneous life loss
    gameBus.SC_GAMESTATUS_StartGame_InLow   = 1'b0;
    gameBus.SC_GAMESTATUS_LifesSignal_InLow = 1'b0;
    step();
    gameBus.SC_GAMESTATUS_StartGame_InLow   = 1'b1;
    gameBus.SC_GAMESTATUS_LifesSignal_InLow = 1'b1;
    chk("restart_lifes", 8'(gameBus.SC_GAMESTATUS_Lifes_OutBUS), 8'h03);
    chk("restart_level", 8'(gameBus.SC_GAMESTATUS_Level_OutBUS), 8'h00);

    // Extra-life behaviour and level saturation
    pulseLifes(); chk("bonus_pre", 8'(gameBus.SC_GAMESTATUS_Lifes_OutBUS), 8'h02);
    completeLevel();
    chk("bonus_l1", 8'(gameBus.SC_GAMESTATUS_Lifes_OutBUS), expBonusLifes);
    completeLevel();
    chk("bonus_l2", 8'(gameBus.SC_GAMESTATUS_Lifes_OutBUS), expBonusLifes);
    chk("lvl2", 8'(gameBus.SC_GAMESTATUS_Level_OutBUS), 8'h02);
    completeLevel();
    chk("lvl3", 8'(gameBus.SC_GAMESTATUS_Level_OutBUS), 8'h03);
    chk("lvl3_cmp", 8'(gameBus.SC_GAMESTATUS_LevelComparator_OutLow), 8'h01);
    completeLevel();
    chk("lvl4", 8'(gameBus.SC_GAMESTATUS_Level_OutBUS), 8'h04);
    chk("lvl4_cmp", 8'(gameBus.SC_GAMESTATUS_LevelComparator_OutLow), 8'h00);
    completeLevel();
    chk("lvl_sat", 8'(gameBus.SC_GAMESTATUS_Level_OutBUS), 8'h04);

    // ClearLost freezes counters; HALT ignores everything but StartGame
    pulseLoad(3'd2); chk("pre_clear_houses", 8'(gameBus.SC_GAMESTATUS_Houses_OutBUS), 8'h04);
    pulseClear();
    chk("clear_houses", 8'(gameBus.SC_GAMESTATUS_Houses_OutBUS), 8'h00);
    chk("clear_lifes",  8'(gameBus.SC_GAMESTATUS_Lifes_OutBUS), expBonusLifes);
    chk("clear_level",  8'(gameBus.SC_GAMESTATUS_Level_OutBUS), 8'h04);
    pulseLifes(); chk("halt_lifes", 8'(gameBus.SC_GAMESTATUS_Lifes_OutBUS), expBonusLifes);
    pulseLoad(3'd1); chk("halt_houses", 8'(gameBus.SC_GAMESTATUS_Houses_OutBUS), 8'h00);
    pulseStart();
    chk("halt_start_lifes", 8'(gameBus.SC_GAMESTATUS_Lifes_OutBUS), 8'h03);
    chk("halt_start_level", 8'(gameBus.SC_GAMESTATUS_Level_OutBUS), 8'h00);
    chk("halt_start_lvlcmp", 8'(gameBus.SC_GAMESTATUS_LevelComparator_OutLow), 8'h01);

    // Reset during LEVELUP kills the pulse immediately
    for (int i = 0; i < 5; i++) pulseLoad(3'(i));
    chk("pre_rst_pulse", 8'(gameBus.SC_GAMESTATUS_NextLevel_OutLow), 8'h00);
    rst = 1'b1;
    #1;
    chk("midrst_next",   8'(gameBus.SC_GAMESTATUS_NextLevel_OutLow), 8'h01);
    chk("midrst_lifes",  8'(gameBus.SC_GAMESTATUS_Lifes_OutBUS), 8'h00);
    chk("midrst_houses", 8'(gameBus.SC_GAMESTATUS_Houses_OutBUS), 8'h00);
    chk("midrst_level",  8'(gameBus.SC_GAMESTATUS_Level_OutBUS), 8'h00);
    step();
    rst = 1'b0;
    step();
    chk("postrst_level", 8'(gameBus.SC_GAMESTATUS_Level_OutBUS), 8'h00);
    chk("postrst_next",  8'(gameBus.SC_GAMESTATUS_NextLevel_OutLow), 8'h01);
    pulseStart();
    chk("postrst_start", 8'(gameBus.SC_GAMESTATUS_Lifes_OutBUS), 8'h03);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
